// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract core with flags and valid/ready backpressure
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: forwarded operands, partial result, segment carry, valid.
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;
    logic              r_ovf;
    logic              r_zero;

    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_b_in   [STAGES];
    logic [WIDTH-1:0]  w_s_in   [STAGES];
    logic [WIDTH-1:0]  w_s_next [STAGES];
    logic [SEG:0]      w_seg    [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_next;
    logic              w_adv;
    logic              w_c_msb;
    logic              w_ovf;
    logic              w_zero;

    assign w_adv = !r_v[LAST] | out_ready;

    always_comb begin
        w_c_in    = '0;
        w_v_in    = '0;
        w_c_next  = '0;
        // Subtraction is folded into the operands at the input so every stage is a plain add.
        w_a_in[0] = op1;
        w_b_in[0] = sub ? ~op2 : op2;
        w_s_in[0] = '0;
        w_c_in[0] = sub | carry_in;
        w_v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_c_in[k] = r_c[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                     + {1'b0, w_b_in[k][k*SEG +: SEG]}
                     + (SEG+1)'(w_c_in[k]);
            w_s_next[k]               = w_s_in[k];
            w_s_next[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
            w_c_next[k]               = w_seg[k][SEG];
        end
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        w_c_msb = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_s_next[LAST][WIDTH-1];
        w_ovf   = w_c_msb ^ w_c_next[LAST];
        w_zero  = ~|w_s_next[LAST];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            r_v <= w_v_in;
            // Data only moves with valid tokens, so outputs hold their last value across bubbles.
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_next[k];
                    r_c[k] <= w_c_next[k];
                end
            end
            if (w_v_in[LAST]) begin
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[LAST];
    assign result    = r_s[LAST];
    assign carry_out = r_c[LAST];
    assign overflow  = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (64/4 directed+random, 8-bit sweep)
module tb_pipelined_adder;
    typedef struct packed {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // Reference: plain unsigned and signed integer arithmetic at width w.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sb, input int w);
        exp_t e;
        logic [65:0] mask, ua, ub, uc, u;
        logic signed [66:0] sa, sbv, sc, sr, one, smax, smin;
        mask = (66'd1 << w) - 66'd1;
        ua   = {2'b00, a};
        ub   = {2'b00, b};
        uc   = {65'd0, cin};
        u    = sb ? (ua - ub) : (ua + ub + uc);
        e.res  = u[63:0] & mask[63:0];
        e.cout = sb ? (ua >= ub) : ((ua + ub + uc) > mask);
        one  = 67'sd1;
        sa   = $signed({3'b000, a});
        sbv  = $signed({3'b000, b});
        sc   = $signed({66'd0, cin});
        if (a[w-1]) sa  = sa  - (one <<< w);
        if (b[w-1]) sbv = sbv - (one <<< w);
        sr   = sb ? (sa - sbv) : (sa + sbv + sc);
        smax = (one <<< (w - 1)) - one;
        smin = -(one <<< (w - 1));
        e.ovf  = (sr > smax) || (sr < smin);
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    // ---------------- 64-bit, 4-stage instance ----------------
    logic        rst_n, in_valid, in_ready, carry_in, sub, out_valid, out_ready;
    logic        carry_out, overflow, zero;
    logic [63:0] op1, op2, result;

    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    task automatic send_one(input logic [63:0] a, input logic [63:0] b,
                            input logic ci, input logic sb, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op1 = a; op2 = b; carry_in = ci; sub = sb; out_ready = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_out(input string name, input exp_t e);
        check({name, "_result"}, result, e.res);
        check({name, "_carry"}, carry_out, e.cout);
        check({name, "_ovf"}, overflow, e.ovf);
        check({name, "_zero"}, zero, e.zero);
    endtask

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        exp_t e, q[$];
        int lat, sent, got, stall_cnt, stale, cyc;
        logic [63:0] sa[8], sbv[8], held;
        logic ci[8], sbb[8];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; carry_in = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry_out, overflow, zero}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Hand-computed literals pin the reference model.
        e = model(64'd5, 64'd7, 1'b1, 1'b0, 64);
        check("model_add", e.res, 64'd13);
        e = model(64'd3, 64'd5, 1'b1, 1'b1, 64);
        check("model_sub", {e.res, e.cout}, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0});

        send_one(64'd5, 64'd7, 1'b1, 1'b0, lat);
        check("t1_latency", lat, 4);
        check_out("t1", '{res: 64'd13, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        send_one('1, 64'd1, 1'b0, 1'b0, lat);
        check_out("t2", '{res: 64'd0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        send_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check_out("t3", '{res: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        send_one(64'd3, 64'd5, 1'b1, 1'b1, lat);
        check_out("t4", '{res: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});

        // Back-to-back stream of 8 with a 3-cycle output stall.
        for (int i = 0; i < 8; i++) begin
            sa[i] = pick64(); sbv[i] = pick64();
            ci[i] = 1'($urandom_range(0, 1)); sbb[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; stall_cnt = 0; held = '0; q = {};
        for (cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 8);
            if (sent < 8) begin
                op1 = sa[sent]; op2 = sbv[sent]; carry_in = ci[sent]; sub = sbb[sent];
            end
            if (out_valid && stall_cnt == 0) begin
                stall_cnt = 1; out_ready = 1'b0; held = result;
            end else if (stall_cnt > 0 && stall_cnt < 3) begin
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_hold", result, held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("stream_spurious", 1, 0);
                else check_out("stream", q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op1, op2, carry_in, sub, 64));
                sent++;
            end
        end
        check("stream_count", got, 8);

        // Reset with three operations in flight.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op1 = 64'(i + 1); op2 = 64'd9; carry_in = 1'b0; sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", {carry_out, overflow, zero}, 0);
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midrst_stale", stale, 0);

        // Randomized traffic with random backpressure.
        sent = 0; q = {};
        for (cyc = 0; cyc < 20000 && (sent < 2000 || q.size() > 0); cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 2000) && ($urandom_range(0, 9) < 8);
            op1 = pick64(); op2 = pick64();
            carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("r64_spurious", 1, 0);
                else check_out("r64", q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op1, op2, carry_in, sub, 64));
                sent++;
            end
        end
        check("r64_drain", {32'(sent), 32'(q.size())}, {32'd2000, 32'd0});
        in_valid = 1'b0;
        done++;
    end

    // ---------------- 8-bit sweep: STAGES = 1, 2, 8 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        logic       s_rst_n, s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
        logic       s_cout, s_ovf, s_zero;
        logic [7:0] s_op1, s_op2, s_result;

        pipelined_adder #(.WIDTH(8), .STAGES(ST)) u_dut (
            .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .op1(s_op1), .op2(s_op2), .carry_in(s_cin), .sub(s_sub),
            .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
            .carry_out(s_cout), .overflow(s_ovf), .zero(s_zero)
        );

        initial begin
            exp_t e, q[$];
            int lat, sent, cyc;
            string nm;
            nm = $sformatf("w8s%0d", ST);
            s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
            s_op1 = '0; s_op2 = '0; s_cin = 1'b0; s_sub = 1'b0;
            repeat (2) @(negedge clk);
            s_rst_n = 1'b1;
            @(negedge clk);
            s_in_valid = 1'b1; s_op1 = 8'hF0; s_op2 = 8'h20; s_cin = 1'b1;
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                s_in_valid = 1'b0;
                if (s_out_valid) begin
                    lat = i;
                    break;
                end
            end
            check({nm, "_latency"}, lat, ST);
            check({nm, "_lat_result"}, {s_result, s_cout, s_ovf, s_zero}, {8'h11, 1'b1, 1'b0, 1'b0});

            sent = 0; q = {};
            for (cyc = 0; cyc < 40000 && (sent < 10000 || q.size() > 0); cyc++) begin
                @(negedge clk);
                s_in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 8);
                s_op1 = 8'($urandom_range(0, 255)); s_op2 = 8'($urandom_range(0, 255));
                s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
                s_out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (s_out_valid && s_out_ready) begin
                    if (q.size() == 0) check({nm, "_spurious"}, 1, 0);
                    else begin
                        e = q.pop_front();
                        check({nm, "_result"}, {56'd0, s_result}, e.res);
                        check({nm, "_flags"}, {s_cout, s_ovf, s_zero}, {e.cout, e.ovf, e.zero});
                    end
                end
                if (s_in_valid && s_in_ready) begin
                    q.push_back(model(64'(s_op1), 64'(s_op2), s_cin, s_sub, 8));
                    sent++;
                end
            end
            check({nm, "_drain"}, {32'(sent), 32'(q.size())}, {32'd10000, 32'd0});
            s_in_valid = 1'b0;
            done++;
        end
    end

    initial begin
        fork
            wait (done == 4);
            #(800_000);
        join_any
        disable fork;
        if (done != 4) check("timeout_done", done, 4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 64-bit ripple-carry adder.
- The carry chain is split into STAGES equal segments, with one register boundary per segment.
- Adds add/subtract mode, status flags and a valid/ready handshake with full backpressure.
- Sits in the ALU datapath as the throughput-oriented adder core for wide operands.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES must be 0; segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- carry_in  input  1  carry into bit 0 (add mode only).
- sub  input  1  0 = op1+op2+carry_in; 1 = op1-op2, i.e. op1+~op2+1 (carry_in ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  sum/difference, mod 2^WIDTH.
- carry_out  output  1  raw carry out of MSB (in sub mode: 1 = no borrow).
- overflow  output  1  signed overflow: MSB carry-in XOR MSB carry-out.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is synchronous and active-low. While rst_n=0 at a rising edge:
  - all stage valid bits clear;
  - out_valid=0, result=0, carry_out=0, overflow=0, zero=0.
  - In-flight operations are discarded, with no partial output.
  - in_ready=1 in the first cycle after reset deasserts.
- Global advance enable: adv = !out_valid | out_ready; in_ready = adv. Combinational, no dependency on in_valid.
- Accept: a transfer occurs when in_valid & in_ready. The effective operand B = sub ? ~op2 : op2 and effective carry c0 = sub ? 1 : carry_in are captured into stage 0.
- Stage k (0..STAGES-1):
  - adds segment k of op1/B with the carry registered from stage k-1 (stage 0 uses c0);
  - registers the SEG-bit partial sum and the segment carry;
  - forwards the upper, not-yet-added operand bits and the already-computed lower result bits unchanged.
  - Each segment is combinational ripple-carry; no combinational carry path crosses a register.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1 when there is no stall. Throughput is 1 result per cycle.
- Stall: when adv=0, every stage register, including its valid bit, holds. Outputs stay stable while out_valid & !out_ready. Bubbles are not compressed under stall; the whole pipeline freezes.
- Bubbles: with in_valid=0 on an adv cycle, stage 0 valid loads 0. Data registers may hold don't-care values, but output flags/result update only with valid data; outputs hold their last value while out_valid=0.
- Flags are computed in the last stage from the final segment:
  - overflow = c[WIDTH-1] ^ c[WIDTH];
  - zero is the full-width reduce-NOR of the assembled result, registered with it.
- STAGES=1: a single registered full-width add with 1-cycle latency and the same handshake.
- Ordering: results leave in acceptance order. No drops or duplicates; each accepted operation yields exactly one out_valid&out_ready transfer.
- Wrap-around: all arithmetic is mod 2^WIDTH; no saturation.

Test Plan (WIDTH=64, STAGES=4 unless noted):
- Reset, then op1=5, op2=7, carry_in=1, sub=0, out_ready=1 → 4 cycles later out_valid=1, result=13, carry_out=0, overflow=0, zero=0.
- op1=0xFFFF_FFFF_FFFF_FFFF, op2=1, sub=0 → result=0, carry_out=1, zero=1, overflow=0. This exercises the carry crossing all 3 stage boundaries.
- Signed overflow and subtract:
  - op1=0x7FFF_FFFF_FFFF_FFFF, op2=1, sub=0 → result=0x8000_0000_0000_0000, overflow=1.
  - op1=3, op2=5, sub=1, carry_in=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0 (borrow); carry_in has no effect.
- Back-to-back stream of 8 ops with in_valid=1. Hold out_ready=0 for 3 cycles once the first result appears:
  - in_ready=0 throughout the stall;
  - result held stable;
  - all 8 results emerge in order, none lost.
- Assert rst_n=0 for 1 cycle with 3 ops in flight → out_valid=0 next cycle, all outputs 0, no stale result emerges afterwards.
- Parameter sweep WIDTH=8 with STAGES=1, 2, 8: random 10k ops checked against a reference model op1±op2. Latency must equal STAGES.
